// File: rtl/fa_pkg.sv
// Shared constants and the golden arithmetic reference for the fa adder.
package fa_pkg;

  // Widest operand the adder supports.
  localparam int FA_MAX_WIDTH = 64;

  // Golden result of a + b + cin at (width+1) bits.
  // - Operands are passed at the maximum width and masked down to 'width'
  //   bits, so one function serves every instance width.
  // - Bit 'width' of the return value is the carry-out.
  // - At width == 64 the shift wraps to zero, which makes the mask all-ones
  //   as intended.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    cin,
    input int unsigned             width
  );
    logic [FA_MAX_WIDTH-1:0] mask;
    logic [FA_MAX_WIDTH:0]   sum;
    mask = (FA_MAX_WIDTH'(1) << width) - FA_MAX_WIDTH'(1);
    sum  = {1'b0, a & mask} + {1'b0, b & mask} + {{FA_MAX_WIDTH{1'b0}}, cin};
    return sum;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder cell, purely combinational.
// Built from plain gates so X/Z on any input propagates to the outputs.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Propagate term, shared by the sum and the carry equations.
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/fa.sv
// Parameterisable ripple-carry adder: {cout,s} = a + b + cin.
// The combinational result is available at zero latency.
// A registered copy (s_q/cout_q) is provided for timing-closed consumers.
module fa
  import fa_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q
);

  // Reject out-of-range widths while the design is being elaborated.
  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $error("fa: WIDTH=%0d outside legal range 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  // Carry chain.
  // - c[0] is the external carry-in.
  // - c[WIDTH] is the carry-out.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, rippling the carry from LSB to MSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    fa_bit u_bit (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (c[gi]),
      .s    (s[gi]),
      .cout (c[gi+1])
    );
  end

  assign cout = c[WIDTH];

  // Output registers.
  // - Reset clears them immediately, without waiting for a clock edge.
  // - Reset only touches these flops; the combinational outputs are
  //   never forced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_fa.sv
// Self-checking bench for fa.
// - Instance u_w1 is the single-bit cell (WIDTH=1).
// - Instance u_w8 is an 8-bit adder (WIDTH=8).
// - Expected values come from plain integer addition done in the bench.
module tb_fa;

  logic       clk;
  logic       rst;

  logic [0:0] a1, b1;
  logic       cin1;
  logic [0:0] s1, s_q1;
  logic       cout1, cout_q1;

  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] s8, s_q8;
  logic       cout8, cout_q8;

  int checks = 0;
  int errors = 0;

  fa #(.WIDTH(1)) u_w1 (
    .clk    (clk),
    .rst    (rst),
    .a      (a1),
    .b      (b1),
    .cin    (cin1),
    .s      (s1),
    .cout   (cout1),
    .s_q    (s_q1),
    .cout_q (cout_q1)
  );

  fa #(.WIDTH(8)) u_w8 (
    .clk    (clk),
    .rst    (rst),
    .a      (a8),
    .b      (b8),
    .cin    (cin8),
    .s      (s8),
    .cout   (cout8),
    .s_q    (s_q8),
    .cout_q (cout_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision unsigned addition.
  function automatic logic [8:0] sum8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[8:0];
  endfunction

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] e;
    logic [8:0] e_prev;
    logic [2:0] v;
    int unsigned t;

    // ---------------- reset state ----------------
    rst  = 1'b1;
    a1   = '0; b1 = '0; cin1 = 1'b0;
    a8   = '0; b8 = '0; cin8 = 1'b0;
    #12;
    chk("rst_s_q1",    s_q1,    1'b0);
    chk("rst_cout_q1", cout_q1, 1'b0);
    chk("rst_s_q8",    s_q8,    8'h00);
    chk("rst_cout_q8", cout_q8, 1'b0);
    chk("zero_s8",     s8,      8'h00);
    chk("zero_cout8",  cout8,   1'b0);
    $display("reset: s_q8=%0h cout_q8=%0b", s_q8, cout_q8);

    // Combinational path is live during reset.
    a8 = 8'h5A;
    #1;
    chk("rst_comb_s8", s8,   8'h5A);
    chk("rst_hold_q8", s_q8, 8'h00);
    rst = 1'b0;
    #1;
    chk("rel_before_edge_q8", s_q8, 8'h00);
    @(posedge clk); #1;
    chk("rel_load_s_q8",    s_q8,    8'h5A);
    chk("rel_load_cout_q8", cout_q8, 1'b0);
    $display("release: s_q8=%0h", s_q8);

    // ---------------- WIDTH=1 exhaustive ----------------
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin1} = v;
      #1;
      t = int'(v[2]) + int'(v[1]) + int'(v[0]);
      chk("w1_s",    s1,    t[0]);
      chk("w1_cout", cout1, t[1]);
      $display("w1 abc=%03b -> cout=%0b s=%0b", v, cout1, s1);
      #4;
    end

    // ---------------- async reset mid-operation ----------------
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk); #1;
    chk("ar_pre_s_q1", s_q1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_s_q1",    s_q1,    1'b0);
    chk("ar_cout_q1", cout_q1, 1'b0);
    chk("ar_s_q8",    s_q8,    8'h00);
    chk("ar_comb_s1", s1,      1'b1);
    @(posedge clk); #1;
    chk("ar_hold_s_q1", s_q1, 1'b0);
    rst = 1'b0;
    #1;
    chk("ar_rel_wait_s_q1", s_q1, 1'b0);
    @(posedge clk); #1;
    chk("ar_rel_s_q1",    s_q1,    1'b1);
    chk("ar_rel_cout_q1", cout_q1, 1'b0);
    $display("async reset: s_q1=%0b cout_q1=%0b", s_q1, cout_q1);

    // ---------------- latency ----------------
    a8 = 8'h10; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'hC3; b8 = 8'h4E; cin8 = 1'b1;
    #1;
    chk("lat_comb_s8",    s8,      8'h12);
    chk("lat_comb_cout8", cout8,   1'b1);
    chk("lat_old_s_q8",   s_q8,    8'h11);
    chk("lat_old_cout_q8", cout_q8, 1'b0);
    @(posedge clk); #1;
    chk("lat_new_s_q8",    s_q8,    8'h12);
    chk("lat_new_cout_q8", cout_q8, 1'b1);
    $display("latency: s8=%0h s_q8=%0h", s8, s_q8);

    // ---------------- WIDTH=8 boundaries ----------------
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    #1;
    chk("bnd_ones_s8",    s8,    8'hFF);
    chk("bnd_ones_cout8", cout8, 1'b1);
    @(posedge clk); #1;
    chk("bnd_ones_s_q8",    s_q8,    8'hFF);
    chk("bnd_ones_cout_q8", cout_q8, 1'b1);
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    #1;
    chk("bnd_wrap_s8",    s8,    8'h00);
    chk("bnd_wrap_cout8", cout8, 1'b1);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    #1;
    chk("bnd_zero_s8",    s8,    8'h00);
    chk("bnd_zero_cout8", cout8, 1'b0);
    $display("boundaries done");

    // ---------------- WIDTH=8 random ----------------
    e_prev = sum8(a8, b8, cin8);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      chk("rnd_s_q8",    s_q8,    e_prev[7:0]);
      chk("rnd_cout_q8", cout_q8, e_prev[8]);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      #1;
      e = sum8(a8, b8, cin8);
      chk("rnd_s8",    s8,    e[7:0]);
      chk("rnd_cout8", cout8, e[8]);
      $display("rnd %0d: %02h+%02h+%0b -> cout=%0b s=%02h", i, a8, b8, cin8, cout8, s8);
      e_prev = e;
    end
    @(posedge clk); #1;
    chk("rnd_last_s_q8",    s_q8,    e_prev[7:0]);
    chk("rnd_last_cout_q8", cout_q8, e_prev[8]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
